// File: rtl/iab_rx.sv
// -----------------------------------------------------------------------------
// iab_rx -- receive end of the IAB byte link.
//
// Collects NBYTES bytes from the IAB bus, one per handshake, into a wide word.
// The word is then offered to the B-side consumer with a ready/accepted
// handshake. Until the B side takes the word, the bus is held off.
//
// Parameters:
//   NBYTES     bytes per frame (>= 2); word width W = 8*NBYTES
//   LSB_FIRST  1: first byte lands in dataB[7:0]; 0: first byte in dataB[W-1:W-8]
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   selI       bus select: the IAB transmitter is addressing this receiver
//   validI     dataIn holds a valid byte
//   dataIn     byte from the IAB bus
//   acceptedI  byte taken this cycle (combinational)
//   dataB      assembled word (registered)
//   readyB     dataB holds a complete frame (registered)
//   acceptedB  B side takes dataB this cycle
//   cntB       bytes collected so far in the current frame (registered)
// -----------------------------------------------------------------------------
module iab_rx #(
    parameter  int NBYTES    = 8,
    parameter  bit LSB_FIRST = 1'b1,
    localparam int W         = 8 * NBYTES,
    localparam int CW        = $clog2(NBYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          selI,
    input  logic          validI,
    input  logic [7:0]    dataIn,
    output logic          acceptedI,
    output logic [W-1:0]  dataB,
    output logic          readyB,
    input  logic          acceptedB,
    output logic [CW-1:0] cntB
);

    typedef enum logic {
        COLLECT = 1'b0,
        DELIVER = 1'b1
    } stateE;

    stateE         state;
    stateE         stateNext;
    logic [W-1:0]  shiftReg;
    logic [W-1:0]  shiftNext;
    logic [W-1:0]  slotWord;
    logic [W-1:0]  dataNext;
    logic          readyNext;
    logic [CW-1:0] cntNext;

    // Low bit position of byte slot k inside the word.
    function automatic int slotLo(input int k);
        return LSB_FIRST ? (8 * k) : (W - 8 - 8 * k);
    endfunction

    // Partial word with the incoming byte dropped into the slot named by cntB.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        slotWord = shiftReg;
        for (int k = 0; k < NBYTES; k++) begin
            if (cntB == CW'(k)) begin
                slotWord[slotLo(k) +: 8] = dataIn;
            end
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        dataNext  = dataB;
        readyNext = readyB;
        cntNext   = cntB;
        // Bus is only served while collecting; reset blocks it immediately.
        acceptedI = selI & validI & (state == COLLECT) & ~rst;

        unique case (state)
            COLLECT: begin
                if (acceptedI) begin
                    if (cntB == CW'(NBYTES - 1)) begin
                        // Last byte: publish the word at this same edge.
                        dataNext  = slotWord;
                        readyNext = 1'b1;
                        cntNext   = '0;
                        shiftNext = '0;
                        stateNext = DELIVER;
                    end else begin
                        shiftNext = slotWord;
                        cntNext   = cntB + CW'(1);
                    end
                end
            end
            DELIVER: begin
                // readyB is always high here, so acceptedB outside DELIVER
                // is ignored without any further qualification.
                if (acceptedB) begin
                    readyNext = 1'b0;
                    stateNext = COLLECT;
                end
            end
            default: stateNext = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is a plain datapath register, but it
            // is cleared so a frame cut short by reset leaves no stale bytes.
            state    <= COLLECT;
            shiftReg <= '0;
            dataB    <= '0;
            readyB   <= 1'b0;
            cntB     <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // register updates from the pre-edge values of its inputs.
            state    <= stateNext;
            shiftReg <= shiftNext;
            dataB    <= dataNext;
            readyB   <= readyNext;
            cntB     <= cntNext;
        end
    end

endmodule

// File: tb/tb_iab_rx.sv
// -----------------------------------------------------------------------------
// tb_iab_rx -- self-checking bench for iab_rx.
//
// Two instances share one stimulus stream: one with LSB_FIRST=1, one with
// LSB_FIRST=0. A byte-queue model predicts every output and is compared on
// each falling edge; directed literal checks pin the model to known words.
// -----------------------------------------------------------------------------
module tb_iab_rx;

    localparam int NBYTES = 8;
    localparam int W      = 8 * NBYTES;
    localparam int CW     = $clog2(NBYTES + 1);

    logic          clk;
    logic          rst;
    logic          selI;
    logic          validI;
    logic [7:0]    dataIn;
    logic          acceptedB;

    logic          accLsb,   accMsb;
    logic [W-1:0]  dataLsb,  dataMsb;
    logic          readyLsb, readyMsb;
    logic [CW-1:0] cntLsb,   cntMsb;

    int vectors     = 0;
    int miscompares = 0;

    iab_rx #(.NBYTES(NBYTES), .LSB_FIRST(1'b1)) uLsb (
        .clk       (clk),
        .rst       (rst),
        .selI      (selI),
        .validI    (validI),
        .dataIn    (dataIn),
        .acceptedI (accLsb),
        .dataB     (dataLsb),
        .readyB    (readyLsb),
        .acceptedB (acceptedB),
        .cntB      (cntLsb)
    );

    iab_rx #(.NBYTES(NBYTES), .LSB_FIRST(1'b0)) uMsb (
        .clk       (clk),
        .rst       (rst),
        .selI      (selI),
        .validI    (validI),
        .dataIn    (dataIn),
        .acceptedI (accMsb),
        .dataB     (dataMsb),
        .readyB    (readyMsb),
        .acceptedB (acceptedB),
        .cntB      (cntMsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is just the list of bytes received; the word is their weighted
    // sum in arrival order (ascending or descending byte significance).
    logic [7:0]   mQ[$];
    bit           mPend = 1'b0;
    logic [63:0]  mLsb  = '0;
    logic [63:0]  mMsb  = '0;
    bit           armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mQ.delete();
            mPend = 1'b0;
            mLsb  = '0;
            mMsb  = '0;
            armed = 1'b1;
        end else if (mPend) begin
            if (acceptedB) mPend = 1'b0;
        end else if (selI && validI) begin
            mQ.push_back(dataIn);
            if (mQ.size() == NBYTES) begin
                mLsb = '0;
                mMsb = '0;
                for (int k = 0; k < NBYTES; k++) begin
                    mLsb = mLsb | (64'(mQ[k]) << (8 * k));
                    mMsb = mMsb | (64'(mQ[k]) << (8 * (NBYTES - 1 - k)));
                end
                mPend = 1'b1;
                mQ.delete();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic expAcc;
        if (armed) begin
            expAcc = selI & validI & ~mPend & ~rst;
            check("accI_lsb",  64'(accLsb),   64'(expAcc));
            check("accI_msb",  64'(accMsb),   64'(expAcc));
            check("ready_lsb", 64'(readyLsb), 64'(mPend));
            check("ready_msb", 64'(readyMsb), 64'(mPend));
            check("cnt_lsb",   64'(cntLsb),   64'(mQ.size()));
            check("cnt_msb",   64'(cntMsb),   64'(mQ.size()));
            check("data_lsb",  dataLsb,       mLsb);
            check("data_msb",  dataMsb,       mMsb);
        end
    end

    // ---------------- directed stimulus ----------------
    logic sawAcc;

    // Drive one cycle of inputs, note acceptedI, and return just after the edge.
    task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic a);
        selI      = s;
        validI    = v;
        dataIn    = d;
        acceptedB = a;
        #1 sawAcc = accLsb;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nAcc;
        logic [63:0] held;
        rst = 1'b1;
        selI = 1'b0; validI = 1'b0; dataIn = '0; acceptedB = 1'b0;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_ready", 64'(readyLsb), 64'd0);
        check("rst_cnt",   64'(cntLsb),   64'd0);
        check("rst_data",  dataLsb,       64'd0);
        rst = 1'b0;

        // 1) Back-to-back frame 0x11..0x88.
        nAcc = 0;
        for (int i = 0; i < NBYTES; i++) begin
            check("t1_cnt_seq", 64'(cntLsb), 64'(i));
            cyc(1'b1, 1'b1, 8'((i + 1) * 17), 1'b0);
            nAcc += int'(sawAcc);
        end
        check("t1_accepts", 64'(nAcc),     64'd8);
        check("t1_ready",   64'(readyLsb), 64'd1);
        check("t1_word_lsb", dataLsb, 64'h8877_6655_4433_2211);
        check("t1_word_msb", dataMsb, 64'h1122_3344_5566_7788);
        check("t1_cnt_wrap", 64'(cntLsb), 64'd0);

        // 2) B side stalls while 0xAA is offered.
        held = dataLsb;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 8'hAA, 1'b0);
            check("t2_stall_acc", 64'(sawAcc), 64'd0);
        end
        check("t2_stall_data", dataLsb, held);
        cyc(1'b1, 1'b1, 8'hAA, 1'b1);
        check("t2_take_acc", 64'(sawAcc),   64'd0);
        check("t2_released", 64'(readyLsb), 64'd0);
        cyc(1'b1, 1'b1, 8'hAA, 1'b0);
        check("t2_aa_acc", 64'(sawAcc), 64'd1);
        check("t2_aa_cnt", 64'(cntLsb), 64'd1);
        for (int i = 1; i < NBYTES; i++) cyc(1'b1, 1'b1, 8'((i + 1) * 17), 1'b0);
        check("t2_word_lsb", dataLsb, 64'h8877_6655_4433_22AA);
        check("t2_word_msb", dataMsb, 64'hAA22_3344_5566_7788);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // 3) Gapped stream, select dropped after byte 4, stray acceptedB.
        for (int i = 0; i < NBYTES; i++) begin
            cyc(1'b1, 1'b1, 8'((i + 1) * 17), 1'b0);
            if (i == 1) begin
                cyc(1'b1, 1'b0, 8'h5A, 1'b1);
                check("t3_strayB_cnt",   64'(cntLsb),   64'd2);
                check("t3_strayB_ready", 64'(readyLsb), 64'd0);
            end else begin
                cyc(1'b1, 1'b0, 8'h5A, 1'b0);
            end
            if (i == 3) begin
                for (int j = 0; j < 3; j++) begin
                    cyc(1'b0, 1'b1, 8'h99, 1'b0);
                    check("t3_nosel_acc", 64'(sawAcc), 64'd0);
                end
                check("t3_hold_cnt", 64'(cntLsb), 64'd4);
            end
        end
        check("t3_word_lsb", dataLsb, 64'h8877_6655_4433_2211);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // 4) Reset mid-frame, then a fresh frame 0x01..0x08.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'((i + 1) * 17), 1'b0);
        check("t4_partial_cnt", 64'(cntLsb), 64'd5);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        check("t4_rst_acc",   64'(sawAcc),   64'd0);
        check("t4_rst_ready", 64'(readyLsb), 64'd0);
        check("t4_rst_cnt",   64'(cntLsb),   64'd0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < NBYTES; i++) cyc(1'b1, 1'b1, 8'(i + 1), 1'b0);
        check("t4_word_lsb", dataLsb, 64'h0807_0605_0403_0201);
        check("t4_word_msb", dataMsb, 64'h0102_0304_0506_0708);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        check("t4_done_ready", 64'(readyLsb), 64'd0);
        check("t4_keep_data",  dataLsb, 64'h0807_0605_0403_0201);

        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iab_rx.md
Name: iab_rx

Overview:
- Receive end of the IAB byte link: the counterpart of the 64-bit-to-byte transmitter (iab).
- Accepts a stream of bytes from the IAB bus while selected, one per handshake, and assembles NBYTES of them into one wide word.
- Presents the word to the B-side consumer with a ready/accepted handshake.
- Applies back-pressure to the bus (acceptedI held low) until the B side has taken the word.

Parameters:
- NBYTES, 8, bytes per frame; word width W = 8*NBYTES; NBYTES >= 2.
- LSB_FIRST, 1, 1: first byte received lands in dataB[7:0]; 0: first byte lands in dataB[W-1:W-8].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- selI  in  1  bus grant/select: the current IAB transmitter is addressing this receiver.
- validI  in  1  dataIn holds a valid byte.
- dataIn  in  8  byte from IAB bus.
- acceptedI  out  1  byte taken this cycle (combinational).
- dataB  out  W  assembled word, registered.
- readyB  out  1  dataB holds a complete frame, registered.
- acceptedB  in  1  B side takes dataB this cycle.
- cntB  out  $clog2(NBYTES+1)  bytes collected so far in the current frame, registered.

Behaviour:
- Reset values (rst=1 at a rising edge):
  - state=COLLECT, cntB=0, readyB=0, dataB=0, internal shift register=0.
  - acceptedI=0 while rst is high.
  - Reset mid-frame or mid-delivery discards the partial or pending word; no output is produced for it.
- Byte transfer: occurs at a rising edge where selI & validI & acceptedI = 1.
  - acceptedI = selI & validI & (state==COLLECT) & ~rst.
  - The transmitter keeps dataIn stable until it sees acceptedI.
- COLLECT:
  - On each transfer, the byte is written into slot cntB and cntB increments.
  - Slot k maps to bits [8k+7:8k] if LSB_FIRST=1, else to bits [W-1-8k : W-8-8k].
  - On the NBYTES-th transfer:
    - The full word is copied to dataB and readyB=1 at the same edge.
    - cntB returns to 0 and state goes to DELIVER.
    - Latency: last byte accepted at edge N -> readyB/dataB valid immediately after edge N.
- DELIVER:
  - acceptedI=0, regardless of selI/validI.
  - dataB is held stable while readyB=1.
  - On an edge with acceptedB=1: readyB=0 and state goes to COLLECT.
  - A byte may be accepted from the next cycle onward; no same-cycle overlap.
- acceptedB while readyB=0 is ignored; no state change.
- selI deasserting mid-frame: cntB and partial data are held, and collection resumes on the next transfer. The frame is not discarded.
- validI=1 with selI=0: no transfer, acceptedI=0.
- Frame boundary is purely by byte count; there is no framing signal. The count wraps to 0 only on frame completion.
- dataB is not cleared on acceptedB; it keeps the last word until it is overwritten.

Test Plan:
- Reset, then send 8 bytes 0x11..0x88 with selI=1, validI=1 every cycle (LSB_FIRST=1):
  - acceptedI high for 8 consecutive cycles.
  - readyB=1 right after the 8th edge with dataB=64'h8877_6655_4433_2211.
  - cntB goes 0..7 then 0.
- Same 8 bytes with B side stalling (acceptedB=0 for 5 cycles) while the transmitter offers byte 0xAA:
  - acceptedI stays 0 and dataB is stable.
  - After acceptedB pulses, 0xAA is accepted on the following cycle and lands in dataB[7:0] of the next frame.
- Gapped stream: validI toggling 1/0, plus selI dropped for 3 cycles after byte 4:
  - cntB holds at 4.
  - The final word is still 64'h8877_6655_4433_2211.
- rst asserted after 5 bytes, then 8 fresh bytes 0x01..0x08:
  - readyB stays 0 through the reset.
  - The next word is 64'h0807_0605_0403_0201; no stale bytes appear.
- LSB_FIRST=0, bytes 0x11..0x88 -> dataB=64'h1122_3344_5566_7788.
- acceptedB pulsed while readyB=0 (mid-frame) -> no effect on cntB, state or readyB.
